// File: rtl/bounce_gen.sv
// Switch-bounce emulator: turns a clean clk-synchronous level into a bouncy copy with a
// pseudo-random toggle burst after each edge, always settling to the new clean level.
module bounce_gen #(
    parameter int          BOUNCE_CYCLES  = 20000,
    parameter int          MIN_HOLD       = 50,
    parameter int          HOLD_RAND_BITS = 8,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        clean_in,
    output logic        bouncy_out,
    output logic        busy,
    output logic [15:0] toggle_count
);
    localparam int WIN_W  = $clog2(BOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(MIN_HOLD + (1 << HOLD_RAND_BITS));

    // An all-zero seed would lock the LFSR, so it is swapped for 1.
    localparam logic [15:0]       SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0]       RAND_MASK = 16'((32'd1 << HOLD_RAND_BITS) - 32'd1);
    localparam logic [WIN_W-1:0]  WIN_LOAD  = WIN_W'(BOUNCE_CYCLES - 1);
    localparam logic [WIN_W-1:0]  WIN_ZERO  = {WIN_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_MIN  = HOLD_W'(MIN_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_BOUNCE = 1'b1;

    logic [0:0]        r_state;
    logic              r_bouncy;
    logic              r_target;
    logic [WIN_W-1:0]  r_window;
    logic [HOLD_W-1:0] r_hold;
    logic [15:0]       r_count;
    logic [15:0]       r_lfsr;

    logic [0:0]        w_state_nxt;
    logic              w_bouncy_nxt;
    logic              w_target_nxt;
    logic [WIN_W-1:0]  w_window_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [15:0]       w_count_nxt;
    logic [15:0]       w_lfsr_nxt;
    logic [HOLD_W-1:0] w_hold_load;
    logic [15:0]       w_count_inc;

    // Next-state logic: LFSR step, bounce window / hold countdown and output toggling.
    always_comb begin
        w_lfsr_nxt   = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        w_hold_load  = HOLD_MIN + HOLD_W'(r_lfsr & RAND_MASK);
        w_count_inc  = (r_count == 16'hFFFF) ? 16'hFFFF : (r_count + 16'd1);
        w_state_nxt  = r_state;
        w_bouncy_nxt = r_bouncy;
        w_target_nxt = r_target;
        w_window_nxt = r_window;
        w_hold_nxt   = r_hold;
        w_count_nxt  = r_count;
        case (r_state)
            ST_IDLE: begin
                if (!enable) begin
                    w_bouncy_nxt = clean_in;
                    w_target_nxt = clean_in;
                end else if (clean_in != r_target) begin
                    w_target_nxt = clean_in;
                    w_bouncy_nxt = clean_in;
                    w_window_nxt = WIN_LOAD;
                    w_hold_nxt   = w_hold_load;
                    w_count_nxt  = 16'd1;
                    w_state_nxt  = ST_BOUNCE;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_BOUNCE: begin
                if (!enable) begin
                    w_bouncy_nxt = clean_in;
                    w_target_nxt = clean_in;
                    w_state_nxt  = ST_IDLE;
                end else if (clean_in != r_target) begin
                    // Re-edge restarts the window only; output and hold carry on.
                    w_target_nxt = clean_in;
                    w_window_nxt = WIN_LOAD;
                end else if (r_window == WIN_ZERO) begin
                    w_bouncy_nxt = r_target;
                    w_state_nxt  = ST_IDLE;
                    if (r_bouncy != r_target) begin
                        w_count_nxt = w_count_inc;
                    end else begin
                        w_count_nxt = r_count;
                    end
                end else begin
                    w_window_nxt = r_window - WIN_W'(1);
                    if (r_hold == HOLD_ZERO) begin
                        w_hold_nxt = w_hold_load;
                        if (r_lfsr[15]) begin
                            w_bouncy_nxt = ~r_bouncy;
                            w_count_nxt  = w_count_inc;
                        end else begin
                            w_bouncy_nxt = r_bouncy;
                        end
                    end else begin
                        w_hold_nxt = r_hold - HOLD_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_bouncy <= 1'b0;
            r_target <= 1'b0;
            r_window <= WIN_ZERO;
            r_hold   <= HOLD_ZERO;
            r_count  <= 16'd0;
            r_lfsr   <= SEED;
        end else begin
            r_state  <= w_state_nxt;
            r_bouncy <= w_bouncy_nxt;
            r_target <= w_target_nxt;
            r_window <= w_window_nxt;
            r_hold   <= w_hold_nxt;
            r_count  <= w_count_nxt;
            r_lfsr   <= w_lfsr_nxt;
        end
    end

    assign bouncy_out   = r_bouncy;
    assign busy         = (r_state == ST_BOUNCE);
    assign toggle_count = r_count;

endmodule

// File: tb/tb_bounce_gen.sv
// Scoreboard bench for bounce_gen: stimulus queues burst/bypass expectations, a monitor checks them.
module tb_bounce_gen;
    localparam int BC  = 64;
    localparam int MH  = 2;
    localparam int HRB = 2;

    typedef struct { int end_cyc; logic level; bit aborted; } burst_t;
    typedef struct { int cyc; logic val; } byp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clean_in = 1'b0;
    logic        bouncy_out, busy, bouncy_z, busy_z;
    logic [15:0] toggle_count, count_z;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    burst_t burst_q[$];
    byp_t   byp_q[$];
    logic [15:0] ref_a = 16'hACE1;
    logic [15:0] ref_z = 16'h0001;
    bit   db_en = 1'b0;
    logic db_out = 1'b0;
    int   db_rises = 0;

    bounce_gen #(.BOUNCE_CYCLES(BC), .MIN_HOLD(MH), .HOLD_RAND_BITS(HRB), .LFSR_SEED(16'hACE1)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clean_in(clean_in),
        .bouncy_out(bouncy_out), .busy(busy), .toggle_count(toggle_count));

    bounce_gen #(.BOUNCE_CYCLES(BC), .MIN_HOLD(MH), .HOLD_RAND_BITS(HRB), .LFSR_SEED(16'h0000)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clean_in(clean_in),
        .bouncy_out(bouncy_z), .busy(busy_z), .toggle_count(count_z));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Reference LFSR sequences for the given seed and for the zero seed (treated as 1).
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            ref_a = 16'hACE1;
            ref_z = 16'h0001;
        end else begin
            ref_a = lfsr_step(ref_a);
            ref_z = lfsr_step(ref_z);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_edge(input logic v);
        @(negedge clk);
        clean_in = v;
        burst_q.push_back('{end_cyc: cyc + 1 + BC, level: v, aborted: 1'b0});
    endtask

    task automatic re_edge(input logic v);
        burst_t e;
        @(negedge clk);
        clean_in = v;
        e = burst_q.pop_back();
        burst_q.push_back('{end_cyc: cyc + 1 + BC, level: v, aborted: 1'b0});
    endtask

    task automatic abort_burst();
        burst_t e;
        @(negedge clk);
        enable = 1'b0;
        e = burst_q.pop_back();
        burst_q.push_back('{end_cyc: cyc + 1, level: clean_in, aborted: 1'b1});
        @(negedge clk);
        enable = 1'b1;
    endtask

    // Monitor: tracks output changes, checks burst boundaries, spacing and bypass following.
    initial begin : monitor
        logic   prev_b, prev_busy;
        int     last_chg, n_chg;
        bit     have_chg;
        burst_t e;
        byp_t   bp;
        prev_b = 1'b0; prev_busy = 1'b0; last_chg = 0; n_chg = 0; have_chg = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_b = bouncy_out; prev_busy = 1'b0; have_chg = 1'b0;
                continue;
            end
            check("lfsr_seeded", 32'(u_dut.r_lfsr), 32'(ref_a));
            check("lfsr_zero_seed", 32'(u_dut_z.r_lfsr), 32'(ref_z));
            if (busy && !prev_busy) begin
                n_chg = 0; have_chg = 1'b0;
                check("first_edge_level", 32'(bouncy_out), 32'(clean_in));
                if (burst_q.size() > 0) check("burst_start_cycle", cyc, burst_q[$].end_cyc - BC);
            end
            if (bouncy_out !== prev_b) begin
                n_chg++;
                if (busy) begin
                    if (have_chg) check("min_hold_spacing", 32'((cyc - last_chg) >= MH), 32'd1);
                    last_chg = cyc; have_chg = 1'b1;
                end
            end
            if (!busy && prev_busy) begin
                if (burst_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL burst_unexpected: burst ended at cycle %0d with none expected", cyc);
                end else begin
                    e = burst_q.pop_front();
                    check("burst_end_cycle", cyc, e.end_cyc);
                    check("final_level", 32'(bouncy_out), 32'(e.level));
                    check("final_equals_clean", 32'(bouncy_out), 32'(clean_in));
                    if (!e.aborted) begin
                        check("toggle_count", 32'(toggle_count), n_chg);
                        check("extra_toggle", 32'(n_chg >= 2), 32'd1);
                    end
                end
            end
            if (burst_q.size() > 0 && cyc > burst_q[0].end_cyc + 4) begin
                checks++; failures++;
                $display("FAIL burst_timeout: expected end at %0d, still busy=%0d at %0d",
                         burst_q[0].end_cyc, busy, cyc);
                e = burst_q.pop_front();
            end
            if (byp_q.size() > 0 && byp_q[0].cyc == cyc) begin
                bp = byp_q.pop_front();
                check("bypass_follow", 32'(bouncy_out), 32'(bp.val));
                check("bypass_busy", 32'(busy), 32'd0);
            end
            prev_b = bouncy_out; prev_busy = busy;
        end
    end

    // Behavioural debouncer with a 7-bit stability counter fed from bouncy_out.
    initial begin : debounce_model
        int db_cnt;
        db_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (db_en && bouncy_out !== db_out) begin
                db_cnt++;
                if (db_cnt >= 127) begin
                    db_out = bouncy_out; db_cnt = 0;
                    if (db_out) db_rises++;
                end
            end else begin
                db_cnt = 0;
            end
        end
    end

    initial begin : stimulus
        logic v;
        int   mode, d;
        repeat (3) @(negedge clk);
        check("reset_bouncy", 32'(bouncy_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_count", 32'(toggle_count), 32'd0);
        rst_n = 1'b1; enable = 1'b1;
        tick(2);
        // Burst deliberately not scoreboarded: it is cut short by reset.
        @(negedge clk); clean_in = 1'b1;
        tick(10);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_bouncy", 32'(bouncy_out), 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_count", 32'(toggle_count), 32'd0);
        clean_in = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        tick(2);

        enable = 1'b0;
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            v = (i == 0) ? 1'b1 : (i == 1 || i == 43) ? 1'b0 : 1'($urandom_range(0, 1));
            clean_in = v;
            byp_q.push_back('{cyc: cyc + 1, val: v});
        end
        @(negedge clk); enable = 1'b1;
        tick(2);

        drive_edge(1'b1);
        tick(BC + 2);
        drive_edge(1'b0);
        tick(BC + 2);

        drive_edge(1'b1);
        tick(19);
        re_edge(1'b0);
        tick(BC + 2);

        for (int i = 0; i < 16; i++) begin
            v    = ~clean_in;
            mode = $urandom_range(0, 3);
            drive_edge(v);
            if (mode == 2) begin
                d = $urandom_range(1, 50);
                tick(d);
                re_edge(~v);
                tick(BC + 2);
            end else if (mode == 3) begin
                d = $urandom_range(5, 50);
                tick(d);
                abort_burst();
                tick(3);
            end else begin
                tick(BC + 2 + $urandom_range(0, 5));
            end
        end

        if (clean_in) begin
            drive_edge(1'b0);
            tick(BC + 2);
        end
        db_out = 1'b0; db_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_edge(1'b1);
            tick(249);
            drive_edge(1'b0);
            tick(249);
            check("debounce_one_rise_per_press", db_rises, i + 1);
        end
        db_en = 1'b0;

        tick(70000);
        check("burst_queue_drained", burst_q.size(), 32'd0);
        check("bypass_queue_drained", byp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
